// File: rtl/hd_codec_pkg.sv
// Shared definitions for the compact bit-pattern code: field layout, op and FSM state encodings.
package hd_codec_pkg;

  localparam int N_LSB   = 0;
  localparam int N_W     = 6;
  localparam int OP_LSB  = 6;
  localparam int OP_W    = 2;
  localparam int PAD_LSB = 8;

  typedef enum logic [OP_W-1:0] {
    OP_LEAD  = 2'd0,
    OP_TRAIL = 2'd1,
    OP_ISOL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/hd_mask_step.sv
// One reconstruction step: advances the accumulator by k bit positions according to the op.
module hd_mask_step
  import hd_codec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 6
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] all_ones;
  assign all_ones = {WIDTH{1'b1}};

  // Shifting by k == WIDTH yields zero, so the complements become all-ones as required.
  always_comb begin
    acc_next = acc;
    case (op)
      OP_LEAD:  acc_next = (acc >> k) | ~(all_ones >> k);
      OP_TRAIL: acc_next = (acc << k) | ~(all_ones << k);
      OP_ISOL:  acc_next = acc << k;
      default:  acc_next = acc;
    endcase
  end

endmodule

// File: rtl/hd_code_expander.sv
// Iterative decoder: accepts one 16-bit pattern code, rebuilds the word STEP bits per cycle,
// and presents the result on a valid/ready output channel.
module hd_code_expander
  import hd_codec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CODE_W = 16,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_word,
  output logic              out_err,
  output logic              busy
);

  localparam int REM_W = $clog2(WIDTH + 1);
  localparam logic [REM_W-1:0] STEP_R  = REM_W'(STEP);
  localparam logic [REM_W-1:0] WIDTH_R = REM_W'(WIDTH);

  state_t             state_reg, state_next;
  logic [REM_W-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  op_t                op_reg, op_next;
  logic               err_reg, err_next;
  logic [WIDTH-1:0]   out_word_reg, out_word_next;
  logic               out_err_reg, out_err_next;
  logic               out_valid_reg, out_valid_next;

  logic [REM_W-1:0]   k;
  logic [WIDTH-1:0]   acc_step;
  int                 code_n;
  op_t                code_op;
  logic               code_bad;

  assign code_n   = int'(in_code[N_LSB +: N_W]);
  assign code_op  = op_t'(in_code[OP_LSB +: OP_W]);
  assign code_bad = (code_op == OP_RSVD) || (in_code[CODE_W-1:PAD_LSB] != '0);
  assign k        = (rem_reg < STEP_R) ? rem_reg : STEP_R;

  hd_mask_step #(
    .WIDTH (WIDTH),
    .KW    (REM_W)
  ) u_step (
    .op       (op_reg),
    .acc      (acc_reg),
    .k        (k),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rem_reg       <= '0;
      acc_reg       <= '0;
      op_reg        <= OP_LEAD;
      err_reg       <= 1'b0;
      out_word_reg  <= '0;
      out_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      acc_reg       <= acc_next;
      op_reg        <= op_next;
      err_reg       <= err_next;
      out_word_reg  <= out_word_next;
      out_err_reg   <= out_err_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    acc_next       = acc_reg;
    op_next        = op_reg;
    err_next       = err_reg;
    out_word_next  = out_word_reg;
    out_err_next   = out_err_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          op_next    = code_op;
          state_next = S_SHIFT;
          if (code_bad) begin
            // Malformed codes skip reconstruction entirely and report a zero word.
            rem_next = '0;
            acc_next = '0;
            err_next = 1'b1;
          end else begin
            rem_next = (code_n > WIDTH) ? WIDTH_R : REM_W'(code_n);
            acc_next = (code_op == OP_ISOL) ? WIDTH'(1) : '0;
            err_next = (code_n > WIDTH);
          end
        end
      end
      S_SHIFT: begin
        if (rem_reg != '0) begin
          rem_next = rem_reg - k;
          acc_next = acc_step;
        end else begin
          out_word_next  = acc_reg;
          out_err_next   = err_reg;
          out_valid_next = 1'b1;
          state_next     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == S_IDLE) && !rst;
  assign busy      = (state_reg != S_IDLE);
  assign out_valid = out_valid_reg;
  assign out_word  = out_word_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_hd_code_expander.sv
// Self-checking bench: directed spec codes, back-pressure, reset abort and random codes vs a reference model.
`timescale 1ns/1ps
module tb_hd_code_expander;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_err, busy;
  logic [31:0] out_word;

  logic        in_valid4 = 1'b0;
  logic [15:0] in_code4 = '0;
  logic        out_ready4 = 1'b0;
  logic        in_ready4, out_valid4, out_err4, busy4;
  logic [31:0] out_word4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hd_code_expander #(.WIDTH(32), .CODE_W(16), .STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_err(out_err), .busy(busy)
  );

  hd_code_expander #(.WIDTH(32), .CODE_W(16), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_code(in_code4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_word(out_word4), .out_err(out_err4), .busy(busy4)
  );

  // Reference: {err, word} straight from the pattern definitions.
  function automatic logic [32:0] ref_result(input logic [15:0] code);
    int n = int'(code[5:0]);
    int op = int'(code[7:6]);
    logic err;
    logic [63:0] w;
    if (op == 3 || code[15:8] != 8'h00) return {1'b1, 32'h0};
    err = (n > 32);
    if (n > 32) n = 32;
    case (op)
      0: w = (n == 0) ? 64'd0 : (((64'd1 << n) - 64'd1) << (32 - n));
      1: w = (64'd1 << n) - 64'd1;
      default: w = (n < 32) ? (64'd1 << n) : 64'd0;
    endcase
    return {err, w[31:0]};
  endfunction

  function automatic int ref_latency(input logic [15:0] code, input int step);
    int n = int'(code[5:0]);
    if (code[7:6] == 2'b11 || code[15:8] != 8'h00) return 1;
    if (n > 32) n = 32;
    return (n + step - 1) / step + 1;
  endfunction

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    c = {8'h00, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 40))};
    if ($urandom_range(0, 7) == 0) c[15:8] = 8'($urandom_range(1, 255));
    if ($urandom_range(0, 7) == 0) c[5:0] = 6'($urandom_range(33, 63));
    return c;
  endfunction

  // One transaction on the STEP=1 instance; hold = cycles of back-pressure, poke = offer a second code meanwhile.
  task automatic do_txn(input logic [15:0] code, input int hold, input bit early, input bit poke);
    int guard = 0;
    int cycles = 0;
    logic [32:0] exp = ref_result(code);
    int exp_lat = ref_latency(code, 1);
    logic [31:0] held_word;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    compared++;
    if (!in_ready) begin mismatched++; $display("FAIL txn_ready_wait code=%h in_ready=%b required 1", code, in_ready); end
    in_code = code; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_code = 16'($urandom);
    if (early) out_ready = 1'b1;
    while (!out_valid && cycles < 100) begin @(posedge clk); #1; cycles++; end
    compared++;
    if (cycles !== exp_lat) begin mismatched++; $display("FAIL latency code=%h got=%0d required=%0d", code, cycles, exp_lat); end
    compared++;
    if (out_word !== exp[31:0]) begin mismatched++; $display("FAIL word code=%h got=%h required=%h", code, out_word, exp[31:0]); end
    compared++;
    if (out_err !== exp[32]) begin mismatched++; $display("FAIL err code=%h got=%b required=%b", code, out_err, exp[32]); end
    $display("txn code=%h word=%h err=%b latency=%0d", code, out_word, out_err, cycles);
    held_word = out_word;
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        if (poke) begin in_valid = 1'b1; in_code = rand_code(); end
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== held_word || busy !== 1'b1) begin
          mismatched++;
          $display("FAIL hold cyc=%0d valid=%b in_ready=%b word=%h busy=%b required 1/0/%h/1", i, out_valid, in_ready, out_word, busy, held_word);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL release code=%h valid=%b in_ready=%b required 0/1", code, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset valid=%b word=%h err=%b in_ready=%b busy=%b required 0/0/0/0/0", out_valid, out_word, out_err, in_ready, busy);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_release in_ready=%b required 1", in_ready); end
    $display("reset checked");
  endtask

  task automatic test_directed();
    logic [15:0] codes [8] = '{16'h0045, 16'h0003, 16'h00A0, 16'h0040, 16'h00C4, 16'h0145, 16'h007F, 16'h0082};
    foreach (codes[i]) do_txn(codes[i], 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_txn(16'h0054, 10, 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    while (!in_ready) begin @(posedge clk); #1; end
    in_code = 16'h0054; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL abort_rst_ready in_ready=%b required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle busy=%b in_ready=%b valid=%b required 0/1/0", busy, in_ready, out_valid);
    end
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    compared++;
    if (seen !== 0) begin mismatched++; $display("FAIL abort_no_output valid_cycles=%0d required 0", seen); end
    $display("reset abort checked");
    do_txn(16'h0041, 0, 1'b0, 1'b0);
  endtask

  task automatic test_step4();
    logic [15:0] codes [6];
    codes[0] = 16'h0049;
    for (int i = 1; i < 6; i++) codes[i] = rand_code();
    foreach (codes[i]) begin
      logic [32:0] exp = ref_result(codes[i]);
      int exp_lat = ref_latency(codes[i], 4);
      int cycles = 0;
      int guard = 0;
      while (!in_ready4 && guard < 100) begin @(posedge clk); #1; guard++; end
      in_code4 = codes[i]; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      while (!out_valid4 && cycles < 100) begin @(posedge clk); #1; cycles++; end
      compared++;
      if (cycles !== exp_lat || out_word4 !== exp[31:0] || out_err4 !== exp[32]) begin
        mismatched++;
        $display("FAIL step4 code=%h got lat=%0d word=%h err=%b required lat=%0d word=%h err=%b",
                 codes[i], cycles, out_word4, out_err4, exp_lat, exp[31:0], exp[32]);
      end
      $display("txn4 code=%h word=%h err=%b latency=%0d", codes[i], out_word4, out_err4, cycles);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 120; t++)
      do_txn(rand_code(), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 20; t++) do_txn(rand_code(), 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_step4();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
